// File: rtl/clk_rec_lock_ctrl_if.sv
// Bundle between the clock-recovery datapath and its lock sequencer.
// Latency: none (wires only).
// Backpressure: none; every field is a level or single-cycle pulse.
interface clk_rec_lock_ctrl_if #(
  parameter int PERIOD_W = 16
);
  logic                edge_pulse;
  logic [PERIOD_W-1:0] period_est;
  logic                key_rev_n;
  logic                key_type_n;
  logic                est_restart;
  logic [PERIOD_W-1:0] init_period;
  logic                rev_pulse;
  logic                type_sel;
  logic                locked;
  logic [1:0]          state;

  // Datapath side: supplies edge events, period estimate and keys.
  modport master (
    output edge_pulse, period_est, key_rev_n, key_type_n,
    input  est_restart, init_period, rev_pulse, type_sel, locked, state
  );

  // Sequencer side.
  modport slave (
    input  edge_pulse, period_est, key_rev_n, key_type_n,
    output est_restart, init_period, rev_pulse, type_sel, locked, state
  );
endinterface

// File: rtl/clk_rec_lock_ctrl.sv
// Lock/acquisition sequencer for bit clock recovery; arbitrates user keys against lock state.
// Latency: every output is registered, one clk_200M cycle after the sampled input event.
// Backpressure: none; edge pulses and key edges are consumed the cycle they are sampled.
// Define CLK_REC_LOS_EN to build the loss-of-signal gap counter and LOST state.
module clk_rec_lock_ctrl #(
  parameter int PERIOD_W     = 16,
  parameter int PERIOD_INIT  = 801,
  parameter int STABLE_EDGES = 16,
  parameter int LOCK_TOL     = 2,
  parameter int MISS_LIMIT   = 4,
  parameter int LOS_SHIFT    = 3
) (
  input  logic               clk_200M,
  input  logic               rst_n,
  clk_rec_lock_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  state_t              state_q, state_nxt;
  logic [PERIOD_W-1:0] ref_period, ref_nxt;
  logic [7:0]          stable_cnt, stable_nxt, stable_inc;
  logic [3:0]          miss_cnt, miss_nxt, miss_inc;
  logic                est_restart_q, est_restart_nxt;
  logic                locked_q;
  logic                key_rev_q, key_type_q;
  logic                rev_pulse_q, type_sel_q;
  logic [PERIOD_W-1:0] diff;
  logic                in_tol;
  logic                type_fall, rev_fall;
  logic                los_trip;

  assign diff       = (bus.period_est >= ref_period) ? (bus.period_est - ref_period)
                                                     : (ref_period - bus.period_est);
  assign in_tol     = (diff <= PERIOD_W'(LOCK_TOL));
  assign stable_inc = stable_cnt + 8'd1;
  assign miss_inc   = miss_cnt + 4'd1;
  assign type_fall  = key_type_q & ~bus.key_type_n;
  assign rev_fall   = key_rev_q & ~bus.key_rev_n;

`ifdef CLK_REC_LOS_EN
  localparam int GAP_W = PERIOD_W + LOS_SHIFT;

  logic [GAP_W-1:0] gap_cnt, gap_nxt, gap_inc, los_thr;
  logic             los_active;

  assign los_active = (state_q == ACQUIRE) || (state_q == LOCKED);
  assign gap_inc    = (gap_cnt == '1) ? gap_cnt : gap_cnt + GAP_W'(1);
  assign los_thr    = GAP_W'(ref_period) << LOS_SHIFT;
  // Trip on the cycle the quiet-time count first exceeds the threshold; an edge that cycle wins.
  assign los_trip   = los_active && !bus.edge_pulse && (ref_period != '0) && (gap_inc > los_thr);

  // Gap counter: clears on every edge, saturates while quiet, idle outside ACQUIRE/LOCKED.
  always_comb begin
    gap_nxt = '0;
    if (los_active) begin
      gap_nxt = bus.edge_pulse ? '0 : gap_inc;
    end
  end

  // Gap counter register.
  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_nxt;
    end
  end
`else
  // No gap counter in this build; the width stays referenced so LOS_SHIFT has a single meaning.
  logic [PERIOD_W+LOS_SHIFT-1:0] unused_gap_cnt;
  assign unused_gap_cnt = '0;
  assign los_trip       = 1'b0;
`endif

  // Next-state and counter updates; type-key drop outranks edge processing, which outranks LOS.
  always_comb begin
    state_nxt       = state_q;
    ref_nxt         = ref_period;
    stable_nxt      = stable_cnt;
    miss_nxt        = miss_cnt;
    est_restart_nxt = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_nxt       = ACQUIRE;
        est_restart_nxt = 1'b1;
        stable_nxt      = '0;
      end
      ACQUIRE: begin
        if (bus.edge_pulse) begin
          ref_nxt = bus.period_est;
          if (in_tol) begin
            stable_nxt = stable_inc;
            if (stable_inc == 8'(STABLE_EDGES)) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else begin
            stable_nxt = '0;
          end
        end else if (los_trip) begin
          state_nxt       = LOST;
          est_restart_nxt = 1'b1;
        end
      end
      LOCKED: begin
        if (type_fall) begin
          state_nxt  = ACQUIRE;
          stable_nxt = '0;
        end else if (bus.edge_pulse) begin
          if (in_tol) begin
            miss_nxt = '0;
          end else begin
            miss_nxt = miss_inc;
            if (miss_inc == 4'(MISS_LIMIT)) begin
              state_nxt  = ACQUIRE;
              stable_nxt = '0;
            end
          end
        end else if (los_trip) begin
          state_nxt       = LOST;
          est_restart_nxt = 1'b1;
        end
      end
      LOST: begin
        if (bus.edge_pulse) begin
          state_nxt  = ACQUIRE;
          stable_nxt = '0;
          ref_nxt    = bus.period_est;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state, counters and registered lock/restart outputs.
  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ref_period    <= '0;
      stable_cnt    <= '0;
      miss_cnt      <= '0;
      est_restart_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      ref_period    <= ref_nxt;
      stable_cnt    <= stable_nxt;
      miss_cnt      <= miss_nxt;
      est_restart_q <= est_restart_nxt;
      locked_q      <= (state_nxt == LOCKED);
    end
  end

  // Key edge detection: one event per press, however long the key is held.
  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      key_rev_q   <= 1'b1;
      key_type_q  <= 1'b1;
      rev_pulse_q <= 1'b0;
      type_sel_q  <= 1'b0;
    end else begin
      key_rev_q   <= bus.key_rev_n;
      key_type_q  <= bus.key_type_n;
      rev_pulse_q <= rev_fall;
      type_sel_q  <= type_sel_q ^ type_fall;
    end
  end

  assign bus.state       = state_q;
  assign bus.locked      = locked_q;
  assign bus.est_restart = est_restart_q;
  assign bus.rev_pulse   = rev_pulse_q;
  assign bus.type_sel    = type_sel_q;
  assign bus.init_period = PERIOD_W'(PERIOD_INIT);

endmodule

// File: tb/tb_clk_rec_lock_ctrl.sv
// Bench for clk_rec_lock_ctrl: directed lock/miss/key/LOS steps, then random traffic,
// each cycle compared against a rule-level model of the sequencer.
module tb_clk_rec_lock_ctrl;
  localparam int PERIOD_W     = 16;
  localparam int PERIOD_INIT  = 801;
  localparam int STABLE_EDGES = 16;
  localparam int LOCK_TOL     = 2;
  localparam int MISS_LIMIT   = 4;
  localparam int LOS_SHIFT    = 3;
  localparam int GAP_MAX      = (1 << (PERIOD_W + LOS_SHIFT)) - 1;

  logic clk_200M;
  logic rst_n;

  clk_rec_lock_ctrl_if #(.PERIOD_W(PERIOD_W)) bus ();

  clk_rec_lock_ctrl #(
    .PERIOD_W    (PERIOD_W),
    .PERIOD_INIT (PERIOD_INIT),
    .STABLE_EDGES(STABLE_EDGES),
    .LOCK_TOL    (LOCK_TOL),
    .MISS_LIMIT  (MISS_LIMIT),
    .LOS_SHIFT   (LOS_SHIFT)
  ) dut (
    .clk_200M(clk_200M),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk_200M = 1'b0;
  always #5 clk_200M = ~clk_200M;

  int vectors = 0;
  int fails   = 0;

  // Reference model: spec-level quantities kept as plain integers.
  int m_state;   // 0 idle, 1 acquire, 2 locked, 3 lost
  int m_ref, m_stable, m_miss, m_gap;
  bit m_rev_q, m_type_q;
  bit e_est, e_rev, e_type, e_locked;

  bit kr_lvl = 1'b1;
  bit kt_lvl = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ref = 0; m_stable = 0; m_miss = 0; m_gap = 0;
    m_rev_q = 1'b1; m_type_q = 1'b1;
    e_est = 1'b0; e_rev = 1'b0; e_type = 1'b0; e_locked = 1'b0;
  endtask

  // One clock of the spec's rules, applied to the inputs sampled at that edge.
  task automatic model_step(input bit ep, input int pe, input bit kr, input bit kt);
    bit tdrop, tol, trip, active;
    int d, nstate;
    tdrop    = m_type_q && !kt;
    e_rev    = m_rev_q && !kr;
    m_type_q = kt;
    m_rev_q  = kr;
    if (tdrop) e_type = !e_type;
    e_est  = 1'b0;
    d      = (pe > m_ref) ? pe - m_ref : m_ref - pe;
    tol    = (d <= LOCK_TOL);
    active = (m_state == 1) || (m_state == 2);
    trip   = 1'b0;
`ifdef CLK_REC_LOS_EN
    if (active) begin
      m_gap = ep ? 0 : ((m_gap < GAP_MAX) ? m_gap + 1 : m_gap);
      trip  = !ep && (m_ref != 0) && (m_gap > (m_ref << LOS_SHIFT));
    end else begin
      m_gap = 0;
    end
`endif
    nstate = m_state;
    if (m_state == 0) begin
      nstate = 1; e_est = 1'b1; m_stable = 0;
    end else if (m_state == 2 && tdrop) begin
      nstate = 1; m_stable = 0;
    end else if (ep) begin
      if (m_state == 1) begin
        m_ref = pe;
        if (tol) begin
          m_stable++;
          if (m_stable == STABLE_EDGES) begin nstate = 2; m_miss = 0; end
        end else m_stable = 0;
      end else if (m_state == 2) begin
        if (tol) m_miss = 0;
        else begin
          m_miss++;
          if (m_miss == MISS_LIMIT) begin nstate = 1; m_stable = 0; end
        end
      end else if (m_state == 3) begin
        nstate = 1; m_stable = 0; m_ref = pe;
      end
    end else if (trip) begin
      nstate = 3; e_est = 1'b1;
    end
    m_state  = nstate;
    e_locked = (m_state == 2);
  endtask

  // Drive one cycle of inputs, advance the model, compare every output.
  task automatic step(input bit ep, input int pe, input bit kr, input bit kt);
    int unsigned pv;
    pv = pe;
    bus.edge_pulse = ep;
    bus.period_est = pv[PERIOD_W-1:0];
    bus.key_rev_n  = kr;
    bus.key_type_n = kt;
    @(posedge clk_200M);
    model_step(ep, pe, kr, kt);
    #1;
    check("state",       32'(bus.state),       32'(m_state));
    check("locked",      32'(bus.locked),      32'(e_locked));
    check("est_restart", 32'(bus.est_restart), 32'(e_est));
    check("rev_pulse",   32'(bus.rev_pulse),   32'(e_rev));
    check("type_sel",    32'(bus.type_sel),    32'(e_type));
    bus.edge_pulse = 1'b0;
  endtask

  task automatic run_edges(input int n, input int pe, input int spacing);
    for (int i = 0; i < n; i++) begin
      repeat (spacing - 1) step(0, pe, kr_lvl, kt_lvl);
      step(1, pe, kr_lvl, kt_lvl);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},       32'(bus.state),       32'd0);
    check({tag, "_locked"},      32'(bus.locked),      32'd0);
    check({tag, "_est_restart"}, 32'(bus.est_restart), 32'd0);
    check({tag, "_rev_pulse"},   32'(bus.rev_pulse),   32'd0);
    check({tag, "_type_sel"},    32'(bus.type_sel),    32'd0);
  endtask

  initial begin
    int n;
    bit seen;
    rst_n          = 1'b0;
    bus.edge_pulse = 1'b0;
    bus.period_est = 16'd100;
    bus.key_rev_n  = 1'b1;
    bus.key_type_n = 1'b1;
    model_reset();
    repeat (3) @(posedge clk_200M);
    #1;
    check_reset_values("rst");
    check("init_period", 32'(bus.init_period), 32'd801);
    rst_n = 1'b1;

    // Restart pulse in the first cycle after release, gone the next.
    step(0, 100, 1, 1);
    check("first_est_restart", 32'(bus.est_restart), 32'd1);
    check("first_state",       32'(bus.state),       32'd1);
    step(0, 100, 1, 1);
    check("est_restart_once",  32'(bus.est_restart), 32'd0);

    // First edge loads the reference, the next 16 in-tolerance edges lock.
    run_edges(16, 100, 100);
    check("lock_not_yet", 32'(bus.locked), 32'd0);
    run_edges(1, 100, 100);
    check("lock_rise", 32'(bus.locked), 32'd1);
    check("lock_state", 32'(bus.state), 32'd2);

    // Three misses then a good edge keeps lock; four misses drop it.
    run_edges(3, 110, 100);
    run_edges(1, 100, 100);
    check("three_miss_keeps_lock", 32'(bus.locked), 32'd1);
    run_edges(3, 110, 100);
    check("three_miss_still_locked", 32'(bus.locked), 32'd1);
    run_edges(1, 110, 100);
    check("four_miss_unlock", 32'(bus.locked), 32'd0);
    check("four_miss_state", 32'(bus.state), 32'd1);
    run_edges(STABLE_EDGES, 100, 100);
    check("relock", 32'(bus.locked), 32'd1);

    // Reverse key while locked: one pulse, state untouched.
    kr_lvl = 1'b0;
    step(0, 100, kr_lvl, kt_lvl);
    check("rev_locked_pulse", 32'(bus.rev_pulse), 32'd1);
    check("rev_locked_state", 32'(bus.state), 32'd2);
    step(0, 100, kr_lvl, kt_lvl);
    check("rev_locked_single", 32'(bus.rev_pulse), 32'd0);
    kr_lvl = 1'b1;
    step(0, 100, kr_lvl, kt_lvl);

    // Type key while locked: toggle and fall back to acquire; holding gives one toggle.
    kt_lvl = 1'b0;
    step(0, 100, kr_lvl, kt_lvl);
    check("type_toggle", 32'(bus.type_sel), 32'd1);
    check("type_drop_state", 32'(bus.state), 32'd1);
    kr_lvl = 1'b0;
    step(0, 100, kr_lvl, kt_lvl);
    check("rev_acq_pulse", 32'(bus.rev_pulse), 32'd1);
    check("rev_acq_state", 32'(bus.state), 32'd1);
    kr_lvl = 1'b1;
    run_edges(10, 100, 100);
    check("type_held_single", 32'(bus.type_sel), 32'd1);
    kt_lvl = 1'b1;
    run_edges(STABLE_EDGES - 10, 100, 100);
    check("relock_after_type", 32'(bus.locked), 32'd1);

`ifdef CLK_REC_LOS_EN
    // Edge landing on the threshold cycle wins: no LOST, no restart.
    repeat (800) step(0, 100, kr_lvl, kt_lvl);
    step(1, 100, kr_lvl, kt_lvl);
    check("edge_at_thr_state", 32'(bus.state), 32'd2);
    check("edge_at_thr_est", 32'(bus.est_restart), 32'd0);
    // Silence: restart pulse after 801 quiet cycles.
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      step(0, 100, kr_lvl, kt_lvl);
      n++;
      if (bus.est_restart === 1'b1) seen = 1'b1;
    end
    check("los_quiet_cycles", 32'(n), 32'd801);
    check("los_state", 32'(bus.state), 32'd3);
    kr_lvl = 1'b0;
    step(0, 100, kr_lvl, kt_lvl);
    check("rev_lost_pulse", 32'(bus.rev_pulse), 32'd1);
    check("rev_lost_state", 32'(bus.state), 32'd3);
    kr_lvl = 1'b1;
    repeat (50) step(0, 100, kr_lvl, kt_lvl);
    step(1, 100, kr_lvl, kt_lvl);
    check("lost_exit_state", 32'(bus.state), 32'd1);
    run_edges(STABLE_EDGES, 100, 100);
    check("relock_after_los", 32'(bus.locked), 32'd1);
`else
    // Without LOS support a long silence leaves lock alone.
    repeat (1200) step(0, 100, kr_lvl, kt_lvl);
    check("no_los_state", 32'(bus.state), 32'd2);
    check("no_los_est", 32'(bus.est_restart), 32'd0);
`endif

    // Random traffic: jittered periods, sporadic keys, a quieter tail.
    for (int i = 0; i < 6000; i++) begin
      bit ep;
      int pe;
      ep = ($urandom_range(0, (i < 4000) ? 59 : 999) == 0);
      pe = 97 + int'($urandom_range(0, 6));
      if ($urandom_range(0, 399) == 0) kt_lvl = !kt_lvl;
      if ($urandom_range(0, 199) == 0) kr_lvl = !kr_lvl;
      step(ep, pe, kr_lvl, kt_lvl);
    end

    // Reset mid-operation clears everything and restarts from idle.
    kr_lvl = 1'b1;
    kt_lvl = 1'b1;
    run_edges(STABLE_EDGES + 1, 100, 50);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    model_reset();
    @(posedge clk_200M);
    #1;
    rst_n = 1'b1;
    step(0, 100, kr_lvl, kt_lvl);
    check("midrst_est_restart", 32'(bus.est_restart), 32'd1);
    run_edges(STABLE_EDGES + 1, 100, 100);
    check("midrst_relock", 32'(bus.locked), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
